// File: rtl/mmio_rd_sched.sv
// mmio_rd_sched: round-robin arbiter feeding one stallable fixed-latency read pipe, returning tagged responses
module mmio_rd_sched #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 64,
  parameter int LATENCY    = 3,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic                             pipe_en,
  output logic [ADDR_WIDTH-1:0]            pipe_addr,
  input  logic [DATA_WIDTH-1:0]            pipe_rdata,
  output logic                             resp_valid,
  output logic [ID_WIDTH-1:0]              resp_id,
  output logic [DATA_WIDTH-1:0]            resp_data,
  input  logic                             resp_ready,
  output logic [$clog2(LATENCY+1)-1:0]     inflight
);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [ID_WIDTH:0] NR = (ID_WIDTH + 1)'(NUM_REQ);

  if (NUM_REQ < 2 || LATENCY < 1) begin : g_bad_param
    $error("mmio_rd_sched: NUM_REQ must be >= 2 and LATENCY >= 1");
  end

  logic [LATENCY-1:0]  r_vld;
  logic [ID_WIDTH-1:0] r_id [LATENCY];
  logic [ID_WIDTH-1:0] r_rr_ptr;
  logic [CW-1:0]       r_inflight;
  logic                w_grant_any;
  logic                w_grant;
  logic                w_acc;
  logic [ID_WIDTH-1:0] w_grant_idx;
  logic [ID_WIDTH:0]   w_sum;
  logic [ID_WIDTH-1:0] w_idx;

  assign resp_valid = r_vld[LATENCY-1];
  assign resp_id    = r_id[LATENCY-1];
  assign resp_data  = pipe_rdata;
  assign pipe_en    = !(resp_valid && !resp_ready);
  assign w_acc      = resp_valid && resp_ready;
  assign w_grant    = w_grant_any && pipe_en;
  assign req_ready  = w_grant ? (NUM_REQ'(1) << w_grant_idx) : '0;
  assign inflight   = r_inflight;

  // Scan from the farthest slot back to rr_ptr so the closest valid requester wins.
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_sum       = '0;
    w_idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_sum = {1'b0, r_rr_ptr} + (ID_WIDTH + 1)'(k);
      w_idx = ID_WIDTH'((w_sum >= NR) ? w_sum - NR : w_sum);
      if (req_valid[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_idx = w_idx;
      end
    end
  end

  always_comb begin
    pipe_addr = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (req_ready[k]) pipe_addr = req_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld      <= '0;
      r_rr_ptr   <= '0;
      r_inflight <= '0;
      for (int k = 0; k < LATENCY; k++) r_id[k] <= '0;
    end else begin
      if (pipe_en) begin
        r_vld[0] <= w_grant;
        r_id[0]  <= w_grant_idx;
        for (int k = 1; k < LATENCY; k++) begin
          r_vld[k] <= r_vld[k-1];
          r_id[k]  <= r_id[k-1];
        end
      end
      if (w_grant) r_rr_ptr <= (w_grant_idx == ID_WIDTH'(NUM_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      if (w_grant != w_acc) r_inflight <= w_grant ? r_inflight + 1'b1 : r_inflight - 1'b1;
    end
  end
endmodule

// File: tb/tb_mmio_rd_sched.sv
// tb_mmio_rd_sched: directed scoreboard bench for the round-robin read scheduler
module tb_mmio_rd_sched;
  localparam int NR = 4, AW = 16, DW = 64, LAT = 3, IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NR-1:0]   req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR-1:0]   req_ready;
  logic            pipe_en;
  logic [AW-1:0]   pipe_addr;
  logic [DW-1:0]   pipe_rdata;
  logic            resp_valid;
  logic [IW-1:0]   resp_id;
  logic [DW-1:0]   resp_data;
  logic            resp_ready = 1'b1;
  logic [1:0]      inflight;

  logic [2:0]      rv3 = '0;
  logic [47:0]     ra3 = '0;
  logic [2:0]      rr3;
  logic            pe3, rsv3;
  logic [1:0]      rid3, inf3;
  logic [15:0]     pa3;
  logic [63:0]     rd3;

  logic [DW-1:0]   d0 = '0, d1 = '0, d2 = '0;
  logic [IW+DW-1:0] q [$];
  logic [IW+DW-1:0] e;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mmio_rd_sched #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .pipe_en(pipe_en), .pipe_addr(pipe_addr), .pipe_rdata(pipe_rdata), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_data(resp_data), .resp_ready(resp_ready), .inflight(inflight));

  mmio_rd_sched #(.NUM_REQ(3), .ADDR_WIDTH(16), .DATA_WIDTH(64), .LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(rv3), .req_addr(ra3), .req_ready(rr3),
    .pipe_en(pe3), .pipe_addr(pa3), .pipe_rdata(64'h0), .resp_valid(rsv3),
    .resp_id(rid3), .resp_data(rd3), .resp_ready(1'b1), .inflight(inf3));

  function automatic logic [63:0] dfn(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5a5a, a + 16'h1234};
  endfunction

  // External read datapath: a stallable 3-stage delay of an address-derived word.
  assign pipe_rdata = d2;
  always @(posedge clk)
    if (pipe_en) begin
      d0 <= dfn(pipe_addr);
      d1 <= d0;
      d2 <= d1;
    end

  always @(negedge clk)
    if (!rst && resp_valid && resp_ready) begin
      n_cmp++;
      if (q.size() == 0) begin
        n_bad++;
        $error("FAIL resp_unexpected: got id=%0d data=%0h, expected no response", resp_id, resp_data);
      end else begin
        e = q.pop_front();
        assert ({resp_id, resp_data} === e) else begin
          n_bad++;
          $error("FAIL resp_sb: got id=%0d data=%0h, expected id=%0d data=%0h",
                 resp_id, resp_data, e[IW+DW-1:DW], e[DW-1:0]);
        end
      end
    end

  task automatic chk(input string t, input logic [127:0] o, input logic [127:0] x);
    n_cmp++;
    assert (o === x) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", t, o, x);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic setaddr(input int i, input logic [15:0] a);
    req_addr[i*AW +: AW] = a;
  endtask

  task automatic grant_chk(input string t, input int id, input logic [15:0] a);
    logic [NR-1:0] x;
    x = NR'(1) << id;
    chk({t, "_ready"}, req_ready, x);
    chk({t, "_addr"}, pipe_addr, a);
    q.push_back({IW'(id), dfn(a)});
  endtask

  initial begin
    idle(2);
    rst = 1'b0;
    mid();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_resp_id", resp_id, 0);
    chk("rst_pipe_en", pipe_en, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_pipe_addr", pipe_addr, 0);
    chk("rst_inflight", inflight, 0);
    cyc();
    // single request
    setaddr(0, 16'h0040);
    req_valid = 4'b0001;
    mid();
    grant_chk("single", 0, 16'h0040);
    cyc();
    req_valid = '0;
    mid();
    chk("single_inflight", inflight, 1);
    chk("single_t1_valid", resp_valid, 0);
    cyc();
    mid();
    chk("single_t2_valid", resp_valid, 0);
    cyc();
    mid();
    chk("single_t3_valid", resp_valid, 1);
    chk("single_t3_id", resp_id, 0);
    cyc();
    mid();
    chk("single_done_inflight", inflight, 0);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    // round-robin fairness
    for (int i = 0; i < NR; i++) setaddr(i, 16'(16'h0100 + i * 4));
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      mid();
      grant_chk("rr", c % 4, 16'(16'h0100 + (c % 4) * 4));
      chk("rr_inflight", inflight, (c < 3) ? c : 3);
      cyc();
    end
    req_valid = '0;
    idle(4);
    mid();
    chk("rr_drained", inflight, 0);
    cyc();
    // backpressure
    for (int i = 0; i < NR; i++) setaddr(i, 16'(16'h0200 + i * 4));
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      mid();
      grant_chk("bp", c, 16'(16'h0200 + c * 4));
      cyc();
    end
    resp_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      mid();
      chk("bp_pipe_en", pipe_en, 0);
      chk("bp_req_ready", req_ready, 0);
      chk("bp_resp_valid", resp_valid, 1);
      chk("bp_resp_id", resp_id, 0);
      chk("bp_resp_data", resp_data, dfn(16'h0200));
      chk("bp_inflight", inflight, 3);
      cyc();
    end
    resp_ready = 1'b1;
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      mid();
      chk("bp_rel_valid", resp_valid, 1);
      chk("bp_rel_id", resp_id, c);
      cyc();
    end
    mid();
    chk("bp_rel_empty", resp_valid, 0);
    cyc();
    // bubble collapse
    setaddr(0, 16'h0300);
    setaddr(1, 16'h0310);
    req_valid = 4'b0001;
    mid();
    grant_chk("bub0", 0, 16'h0300);
    cyc();
    req_valid = '0;
    resp_ready = 1'b0;
    mid();
    chk("bub_t1_pipe_en", pipe_en, 1);
    cyc();
    req_valid = 4'b0010;
    mid();
    chk("bub_t2_pipe_en", pipe_en, 1);
    grant_chk("bub2", 1, 16'h0310);
    cyc();
    req_valid = '0;
    mid();
    chk("bub_t3_pipe_en", pipe_en, 0);
    chk("bub_t3_valid", resp_valid, 1);
    chk("bub_t3_id", resp_id, 0);
    cyc();
    resp_ready = 1'b1;
    idle(5);
    // reset with two reads in flight
    setaddr(2, 16'h0400);
    setaddr(3, 16'h0410);
    req_valid = '1;
    mid();
    chk("rmf_g2", req_ready, 4'b0100);
    cyc();
    mid();
    chk("rmf_g3", req_ready, 4'b1000);
    cyc();
    req_valid = '0;
    rst = 1'b1;
    mid();
    chk("rmf_inflight_pre", inflight, 2);
    cyc();
    rst = 1'b0;
    mid();
    chk("rmf_inflight_post", inflight, 0);
    for (int c = 0; c < 4; c++) begin
      chk("rmf_no_resp", resp_valid, 0);
      cyc();
      mid();
    end
    cyc();
    setaddr(0, 16'h0500);
    req_valid = '1;
    mid();
    grant_chk("rmf_next", 0, 16'h0500);
    cyc();
    req_valid = '0;
    idle(5);
    // NUM_REQ=3 wrap and skip
    ra3[15:0] = 16'h0A00;
    ra3[31:16] = 16'h0A10;
    rv3 = 3'b010;
    mid();
    chk("nr3_g1", rr3, 3'b010);
    chk("nr3_g1_addr", pa3, 16'h0A10);
    cyc();
    rv3 = 3'b011;
    mid();
    chk("nr3_wrap", rr3, 3'b001);
    chk("nr3_wrap_addr", pa3, 16'h0A00);
    cyc();
    mid();
    chk("nr3_next", rr3, 3'b010);
    cyc();
    rv3 = '0;
    idle(2);
    chk("sb_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mmio_rd_sched.md
# mmio_rd_sched

Round-robin scheduler that shares one fixed-latency read pipeline (a `delay` instance of `LATENCY` cycles, or any equivalent stallable pipeline) among `NUM_REQ` MMIO read requesters. It grants at most one request per cycle and drives the pipeline's address and enable. It carries a requester-ID/valid tag alongside the pipeline and returns each response, tagged, with downstream backpressure. It sits between the MMIO decode logic and the multi-cycle read datapath.

## Interface
- `NUM_REQ`, default 4: number of requesters; must be at least 2.
- `ADDR_WIDTH`, default 16: read address width.
- `DATA_WIDTH`, default 64: read data width.
- `LATENCY`, default 3: pipeline depth in cycles; must be at least 1. Elaboration `$error` if violated.
- `ID_WIDTH`, default `$clog2(NUM_REQ)`: tag width.

Ports:
- `clk`  in  1  clock; the block has this single clock.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester read request.
- `req_addr`  in  NUM_REQ x ADDR_WIDTH  per-requester address.
- `req_ready`  out  NUM_REQ  one-hot grant; the request is accepted when `req_valid[i] && req_ready[i]`.
- `pipe_en`  out  1  enable to the pipeline; also advances the internal tag pipe.
- `pipe_addr`  out  ADDR_WIDTH  address of the granted requester; 0 when there is no grant.
- `pipe_rdata`  in  DATA_WIDTH  pipeline output, aligned with tag stage `LATENCY-1`.
- `resp_valid`  out  1  response available.
- `resp_id`  out  ID_WIDTH  index of the requester owning the response.
- `resp_data`  out  DATA_WIDTH  equals `pipe_rdata`.
- `resp_ready`  in  1  downstream accepts the response.
- `inflight`  out  $clog2(LATENCY+1)  count of valid tags in the pipe.

## Operation
- **Tag pipe.**
  - `LATENCY` stages, each holding {valid, id}. Stage 0 loads {grant_any, grant_idx}.
  - Stage k+1 loads stage k.
  - The pipe shifts only when `pipe_en`=1. When `pipe_en`=0, all stages hold.
- **Stall rule.** `pipe_en = !(tag[LATENCY-1].valid && !resp_ready)`. The pipe advances on bubbles and on accepted responses, and freezes only on a blocked valid response.
- **Response outputs.** `resp_valid = tag[LATENCY-1].valid`, `resp_id = tag[LATENCY-1].id`, and `resp_data = pipe_rdata`, all combinational.
- **Arbitration.**
  - Combinational round-robin over `req_valid`. The search starts at pointer `rr_ptr` and wraps modulo `NUM_REQ`.
  - Grant is issued only when `pipe_en`=1. When `pipe_en`=0, `req_ready` is all zeros.
  - Grant does not depend on `req_ready` feedback; `req_ready[i]` may only be asserted when `req_valid[i]`=1.
- **Pointer update.** On a grant to index i, `rr_ptr <= (i+1) mod NUM_REQ`. With no grant, `rr_ptr` holds.
- **In-flight counter.**
  - `inflight` increments on a grant with no response accepted.
  - It decrements on a response accepted with no grant.
  - It holds when both or neither occur.
  - The counter never exceeds `LATENCY`, which is guaranteed by construction.
- **Arithmetic.** Pointer and ID compare are unsigned, width `ID_WIDTH`. Wrap from `NUM_REQ-1` to 0 is explicit, so it is correct for non-power-of-2 `NUM_REQ`.

## Timing
- **Reset values.** All tag valids are 0, `rr_ptr` is 0, and `inflight` is 0. As a result `resp_valid`=0, `resp_id`=0, `pipe_en`=1, `req_ready`=0 (absent requests), and `pipe_addr`=0.
- **Latency.** A request granted in cycle T returns with `resp_valid`=1 in cycle T+`LATENCY`, plus the number of stall cycles in between.
- **Throughput.** One grant per cycle when unstalled. Back-to-back responses are allowed.
- **Simultaneous events.**
  - A response accepted and a new grant in the same cycle are both legal; `inflight` is unchanged.
  - A blocked response, meaning `resp_ready` is low while a response is valid, gives zero grants that cycle.
- **Reset mid-operation.** A synchronous `rst` clears all tags and the pointer on the next edge. In-flight reads are discarded, and no `resp_valid` is produced for them. Stale data in an async-reset pipeline is harmless because the tags are invalid.
- **Handshake.** `resp_*` stays stable while `resp_valid && !resp_ready`, because the pipe is frozen.

## Test plan
- **Single request, LATENCY=3.** `req_valid`=0001 at T0 with address 0x0040. Required: `req_ready`=0001 at T0, `pipe_addr`=0x0040, then `resp_valid`=1 and `resp_id`=0 at T3.
- **Round-robin fairness.** All 4 requesters held valid continuously with `resp_ready`=1. Required: grants 0,1,2,3,0,… one per cycle, and `inflight` saturates at 3.
- **Backpressure.** After 3 back-to-back grants, hold `resp_ready`=0 for 5 cycles. Required:
  - `pipe_en`=0, `req_ready`=0, and `resp_id`/`resp_data` stable throughout.
  - On release, the remaining responses arrive on consecutive cycles in issue order.
- **Pointer wrap and skip.**
  - `NUM_REQ`=3 with `rr_ptr`=2: requests from 0 and 1 only get a grant to 0, then `rr_ptr`=1.
  - Next, requests from 0 and 1 get a grant to 1.
- **Reset mid-flight.** Assert `rst` for 1 cycle with 2 reads in flight. Required: no `resp_valid` for the discarded reads, `inflight`=0, and the next grant goes to requester 0 first.
- **Bubble collapse.**
  - Grant at T0 only, with `resp_ready`=0 from T1.
  - Required: `pipe_en` stays 1 until T3, when the valid tag reaches stage 2.
  - A new request at T2 is still granted.
